// File: rtl/output_drain.sv
// Requantizes convolution accumulations to the IO word format and drains them through
// a small FIFO over valid/ready; results the producer pushes into a full FIFO are dropped and counted.
module output_drain #(
    parameter  int ACC_WIDTH          = 32,
    parameter  int IO_DATA_WIDTH      = 16,
    parameter  int FEATURE_MAP_WIDTH  = 1024,
    parameter  int FEATURE_MAP_HEIGHT = 1024,
    parameter  int OUTPUT_NB_CHANNELS = 64,
    parameter  int OUTPUT_SCALE       = 0,
    parameter  int FIFO_DEPTH         = 8,
    localparam int XW   = $clog2(FEATURE_MAP_WIDTH),
    localparam int YW   = $clog2(FEATURE_MAP_HEIGHT),
    localparam int CW   = $clog2(OUTPUT_NB_CHANNELS),
    localparam int CNTW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_in,
    input  logic                            in_valid,
    input  logic signed [ACC_WIDTH-1:0]     in_acc,
    input  logic        [XW-1:0]            in_x,
    input  logic        [YW-1:0]            in_y,
    input  logic        [CW-1:0]            in_ch,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [IO_DATA_WIDTH-1:0] out_data,
    output logic        [XW-1:0]            out_x,
    output logic        [YW-1:0]            out_y,
    output logic        [CW-1:0]            out_ch,
    output logic                            out_last,
    output logic        [CNTW-1:0]          fifo_count,
    output logic                            overflow,
    output logic        [15:0]              drop_count,
    output logic                            frame_done,
    input  logic                            clear_in
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Requantization arithmetic is one bit wider than the accumulator so the rounding add cannot wrap.
    localparam logic signed [ACC_WIDTH:0] ROUND   = ((ACC_WIDTH+1)'(1) << OUTPUT_SCALE) >> 1;
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2 ** (IO_DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    typedef struct packed {
        logic [IO_DATA_WIDTH-1:0] data;
        logic [XW-1:0]            x;
        logic [YW-1:0]            y;
        logic [CW-1:0]            ch;
        logic                     last;
    } entry_t;

    logic signed [ACC_WIDTH:0]     acc_ext;
    logic signed [ACC_WIDTH:0]     acc_sum;
    logic signed [ACC_WIDTH:0]     shifted;
    logic        [IO_DATA_WIDTH-1:0] q;
    logic                          in_last;

    entry_t          s1_entry;
    logic            s1_valid;

    entry_t          mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    entry_t          head;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    assign acc_ext = {in_acc[ACC_WIDTH-1], in_acc};
    assign acc_sum = acc_ext + ROUND;
    assign shifted = acc_sum >>> OUTPUT_SCALE;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        q = shifted[IO_DATA_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            q = SAT_MAX[IO_DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            q = SAT_MIN[IO_DATA_WIDTH-1:0];
        end
    end

    assign in_last = (in_x == XW'(FEATURE_MAP_WIDTH - 1)) &&
                     (in_y == YW'(FEATURE_MAP_HEIGHT - 1)) &&
                     (in_ch == CW'(OUTPUT_NB_CHANNELS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_entry <= '{data: q, x: in_x, y: in_y, ch: in_ch, last: in_last};
            end
        end
    end

    assign full = (count == CNTW'(FIFO_DEPTH));
    assign pop  = out_valid && out_ready;
    // A pop frees the slot at the same edge, so a push into a full FIFO still succeeds then.
    assign push = s1_valid && (!full || pop);
    assign drop = s1_valid && full && !pop;

    // NOTE: storage is not reset; head fields are masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s1_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            frame_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase

            if (drop) begin
                overflow   <= 1'b1;
                if (clear_in) begin
                    drop_count <= 16'd1;
                end else if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end else if (clear_in) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end

            frame_done <= pop && head.last;
        end
    end

    assign head       = mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign fifo_count = count;

    always_comb begin
        out_data = '0;
        out_x    = '0;
        out_y    = '0;
        out_ch   = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_data = head.data;
            out_x    = head.x;
            out_y    = head.y;
            out_ch   = head.ch;
            out_last = head.last;
        end
    end

endmodule

// File: tb/tb_output_drain.sv
// Scoreboard bench for output_drain: two instances (shift 0 and shift 4) share stimulus; expected
// entries are queued when driven and compared as each head is popped.
module tb_output_drain;

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d4;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [5:0]  ch;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_acc = '0;
    logic [9:0]  in_x = '0;
    logic [9:0]  in_y = '0;
    logic [5:0]  in_ch = '0;
    logic        out_ready = 1'b0;
    logic        clear_in = 1'b0;

    logic        out_valid, out_last, overflow, frame_done;
    logic [15:0] out_data, drop_count;
    logic [9:0]  out_x, out_y;
    logic [5:0]  out_ch;
    logic [3:0]  fifo_count;

    logic        v4, last4, ovf4, fd4;
    logic [15:0] data4, drops4;
    logic [9:0]  x4, y4;
    logic [5:0]  ch4;
    logic [3:0]  cnt4;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    output_drain #(.OUTPUT_SCALE(0)) dut (
        .clk(clk), .rst_in(rst_in), .in_valid(in_valid), .in_acc(in_acc),
        .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_ch(out_ch), .out_last(out_last),
        .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count),
        .frame_done(frame_done), .clear_in(clear_in)
    );

    output_drain #(.OUTPUT_SCALE(4)) dut4 (
        .clk(clk), .rst_in(rst_in), .in_valid(in_valid), .in_acc(in_acc),
        .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
        .out_valid(v4), .out_ready(out_ready), .out_data(data4),
        .out_x(x4), .out_y(y4), .out_ch(ch4), .out_last(last4),
        .fifo_count(cnt4), .overflow(ovf4), .drop_count(drops4),
        .frame_done(fd4), .clear_in(clear_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] requant(input logic [31:0] acc, input int sh);
        longint v;
        v = longint'($signed(acc));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    // Drives one result for one cycle; expect=0 marks an entry that must be dropped or flushed.
    task automatic send(input logic [31:0] acc, input int x, input int y, input int ch, input bit expect_it);
        exp_t e;
        in_valid = 1'b1;
        in_acc   = acc;
        in_x     = 10'(x);
        in_y     = 10'(y);
        in_ch    = 6'(ch);
        if (expect_it) begin
            e.d0   = requant(acc, 0);
            e.d4   = requant(acc, 4);
            e.x    = 10'(x);
            e.y    = 10'(y);
            e.ch   = 6'(ch);
            e.last = (x == 1023) && (y == 1023) && (ch == 63);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string tag);
        int budget;
        out_ready = 1'b1;
        budget = 0;
        while ((exp_q.size() != 0 || fifo_count != 0) && budget < 200) begin
            tick(1);
            budget++;
        end
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_cnt"}, 32'(fifo_count), 0);
    endtask

    // Head is compared just before the edge that pops it.
    always @(negedge clk) begin
        if (!rst_in && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'(out_valid), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pop_data",  32'(out_data), 32'(e.d0));
                check("pop_data4", 32'(data4),    32'(e.d4));
                check("pop_x",     32'(out_x),    32'(e.x));
                check("pop_y",     32'(out_y),    32'(e.y));
                check("pop_ch",    32'(out_ch),   32'(e.ch));
                check("pop_last",  32'(out_last), 32'(e.last));
                check("pop_v4",    32'(v4),       32'(out_valid));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        tick(2);
        check("rst_valid",  32'(out_valid),  0);
        check("rst_data",   32'(out_data),   0);
        check("rst_tags",   {out_x, out_y, out_ch}, 0);
        check("rst_last",   32'(out_last),   0);
        check("rst_count",  32'(fifo_count), 0);
        check("rst_ovf",    32'(overflow),   0);
        check("rst_drops",  32'(drop_count), 0);
        check("rst_fdone",  32'(frame_done), 0);
        rst_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_valid", 32'(out_valid), 0);
        end

        // Latency and tags
        out_ready = 1'b1;
        send(32'd123, 5, 7, 3, 1'b1);
        check("lat_c1_valid", 32'(out_valid), 0);
        tick(1);
        check("lat_c2_valid", 32'(out_valid), 1);
        check("lat_c2_data",  32'(out_data),  123);
        check("lat_c2_tags",  {out_x, out_y, out_ch}, {10'd5, 10'd7, 6'd3});
        tick(1);
        check("lat_count0", 32'(fifo_count), 0);

        // Rounding and saturation, back to back
        send(32'd296,        1, 0, 0, 1'b1);
        send(-32'sd24,       2, 0, 0, 1'b1);
        send(32'h0010_0000,  3, 0, 0, 1'b1);
        send(-32'sd40000,    4, 0, 0, 1'b1);
        send(32'h7FFF_FFFF,  5, 1, 1, 1'b1);
        send(32'h8000_0000,  6, 2, 2, 1'b1);
        send(-32'sd8,        7, 3, 3, 1'b1);
        drain("round");

        // Overflow: 11 results, 3 dropped
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send(32'(100 + i), i, 1, 2, i < 8);
        tick(1);
        check("ovf_count", 32'(fifo_count), 8);
        check("ovf_flag",  32'(overflow),   1);
        check("ovf_drops", 32'(drop_count), 3);
        check("ovf_drops4", 32'(drops4),    3);
        drain("ovf");
        check("ovf_sticky", 32'(overflow), 1);

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(32'(200 + i), i, 2, 0, 1'b1);
        check("full_count", 32'(fifo_count), 8);
        out_ready = 1'b1;
        for (int i = 9; i < 15; i++) begin
            send(32'(200 + i), i, 2, 0, 1'b1);
            check("full_pp_count", 32'(fifo_count), 8);
            check("full_pp_drops", 32'(drop_count), 3);
        end
        drain("full");
        clear_in = 1'b1;
        tick(1);
        clear_in = 1'b0;
        check("clr_ovf",   32'(overflow),   0);
        check("clr_drops", 32'(drop_count), 0);

        // Drop and clear at the same edge: drop wins
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(32'(300 + i), i, 3, 0, 1'b1);
        send(32'd999, 9, 3, 0, 1'b0);
        clear_in = 1'b1;
        tick(1);
        clear_in = 1'b0;
        check("dc_ovf",   32'(overflow),   1);
        check("dc_drops", 32'(drop_count), 1);
        drain("dc");

        // Frame end
        out_ready = 1'b0;
        send(32'd77, 1023, 1023, 63, 1'b1);
        tick(1);
        check("fe_head_last", 32'(out_last),   1);
        check("fe_fdone_pre", 32'(frame_done), 0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("fe_fdone",      32'(frame_done), 1);
        check("fe_fdone4",     32'(fd4),        1);
        tick(1);
        check("fe_fdone_post", 32'(frame_done), 0);

        // Reset with entries queued
        for (int i = 0; i < 4; i++) send(32'(400 + i), i, 4, 0, 1'b0);
        tick(1);
        check("mid_count", 32'(fifo_count), 4);
        rst_in = 1'b1;
        tick(1);
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_valid", 32'(out_valid),  0);
        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("post_rst_valid", 32'(out_valid), 0);
        end
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
